// File: rtl/dcp_spmv_pkg.sv
// Shared definitions for the SpMV line server.
// Holds the widths used on the DCP NoC side, the cache line geometry, and the
// response entry carried through the response queue.
package dcp_spmv_pkg;

   // NoC response payload width and physical address width (DCP_PADDR_MASK is [39:0]).
   localparam int NOC_RES_DATA_SIZE = 512;
   localparam int PADDR_W           = 40;

   localparam int LINE_BYTES = 64;
   localparam int LINE_SHIFT = 6;
   localparam int TRANSID_W  = 6;

   typedef struct packed {
      logic [TRANSID_W-1:0]         transid;
      logic                         err;
      logic [NOC_RES_DATA_SIZE-1:0] data;
   } resp_entry_t;

endpackage

// File: rtl/spmv_resp_fifo.sv
// Response queue for spmv_line_server.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clr             - synchronous clear of pointers and count (storage kept)
//   push, push_data - write one entry at the tail
//   pop             - drop the head entry (ignored when empty)
//   head            - current head entry (meaningless when count == 0)
//   count           - number of stored entries, 0..QDEPTH
// The caller guarantees no push when full; a simultaneous push and pop keeps
// count unchanged.
module spmv_resp_fifo #(
   parameter type entry_t = logic,
   parameter int  QDEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push,
   input  entry_t                 push_data,
   input  logic                   pop,
   output entry_t                 head,
   output logic [$clog2(QDEPTH):0] count
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = $clog2(QDEPTH) + 1;

   entry_t             mem_q [QDEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               pop_ok;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_ok   = pop && (count_q != '0);
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointers wrap modulo QDEPTH, which need not be a power of two.
         if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is not reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/spmv_line_server.sv
// SpMV line server: a window of DEPTH 64-byte lines answering NoC line reads.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drop all in-flight work; line contents kept
//   base_addr           - window base address, low 6 bits ignored
//   load_val/idx/data   - line fill port, has priority over requests
//   mem_req_*           - read request channel (val/rdy/transid/addr)
//   mem_resp_*          - response channel (val/rdy/transid/data/err)
// Handshake: a transfer happens on a cycle where val and rdy are both 1;
// a sender holds its payload stable while val=1 and rdy=0.
// Latency: a request accepted at cycle N is at the response head at cycle N+2.
module spmv_line_server
   import dcp_spmv_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int LINE_W = NOC_RES_DATA_SIZE,  // must equal NOC_RES_DATA_SIZE
   parameter int QDEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [PADDR_W-1:0]       base_addr,
   input  logic                     load_val,
   input  logic [$clog2(DEPTH)-1:0] load_idx,
   input  logic [LINE_W-1:0]        load_data,
   input  logic                     mem_req_val,
   output logic                     mem_req_rdy,
   input  logic [TRANSID_W-1:0]     mem_req_transid,
   input  logic [PADDR_W-1:0]       mem_req_addr,
   output logic                     mem_resp_val,
   input  logic                     mem_resp_rdy,
   output logic [TRANSID_W-1:0]     mem_resp_transid,
   output logic [LINE_W-1:0]        mem_resp_data,
   output logic                     mem_resp_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam int OFF_W = PADDR_W - LINE_SHIFT;

   logic [LINE_W-1:0]    line_mem_q [DEPTH];

   logic                 s1_val_q, s1_val_d;
   logic [IDX_W-1:0]     s1_idx_q, s1_idx_d;
   logic [TRANSID_W-1:0] s1_transid_q, s1_transid_d;
   logic                 s1_err_q, s1_err_d;

   logic [OFF_W-1:0]     line_off;
   logic                 req_err;
   logic                 accept;
   logic [CNT_W-1:0]     fifo_count;
   logic [CNT_W-1:0]     inflight;
   logic [CNT_W:0]       occupancy;
   logic [LINE_W-1:0]    rd_data;
   resp_entry_t          push_entry;
   resp_entry_t          head_entry;
   logic                 pop;
   logic                 unused_low_bits;

   // Byte offsets inside a line never matter, so work in line units.
   assign unused_low_bits = ^{base_addr[LINE_SHIFT-1:0], mem_req_addr[LINE_SHIFT-1:0]};

   always_comb begin
      line_off = mem_req_addr[PADDR_W-1:LINE_SHIFT] - base_addr[PADDR_W-1:LINE_SHIFT];
      // Below-base addresses wrap line_off, so test them separately.
      req_err  = (mem_req_addr[PADDR_W-1:LINE_SHIFT] < base_addr[PADDR_W-1:LINE_SHIFT]) ||
                 (line_off >= OFF_W'(DEPTH));

      inflight    = {{(CNT_W-1){1'b0}}, s1_val_q};
      occupancy   = {1'b0, fifo_count} + {1'b0, inflight};
      mem_req_rdy = !rst && !flush && !load_val && (occupancy < (CNT_W+1)'(QDEPTH));
      accept      = mem_req_val && mem_req_rdy;

      s1_val_d     = accept;
      s1_idx_d     = accept ? line_off[IDX_W-1:0] : s1_idx_q;
      s1_transid_d = accept ? mem_req_transid : s1_transid_q;
      s1_err_d     = accept ? req_err : s1_err_q;
      if (flush) begin
         s1_val_d = 1'b0;
      end

      // Stage 2 reads at the edge where the FIFO captures; forward a same-cycle
      // load so the response reflects the line as written that cycle.
      rd_data = (load_val && (load_idx == s1_idx_q)) ? load_data : line_mem_q[s1_idx_q];

      push_entry.transid = s1_transid_q;
      push_entry.err     = s1_err_q;
      push_entry.data    = s1_err_q ? '0 : rd_data;

      mem_resp_val     = !rst && (fifo_count != '0);
      mem_resp_transid = mem_resp_val ? head_entry.transid : '0;
      mem_resp_err     = mem_resp_val ? head_entry.err : 1'b0;
      mem_resp_data    = mem_resp_val ? head_entry.data : '0;
      pop              = mem_resp_val && mem_resp_rdy;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_val_q     <= 1'b0;
         s1_idx_q     <= '0;
         s1_transid_q <= '0;
         s1_err_q     <= 1'b0;
      end else begin
         s1_val_q     <= s1_val_d;
         s1_idx_q     <= s1_idx_d;
         s1_transid_q <= s1_transid_d;
         s1_err_q     <= s1_err_d;
      end
   end

   // Line storage is never cleared; reset only blocks a coincident load.
   always_ff @(posedge clk) begin
      if (load_val && !rst) begin
         line_mem_q[load_idx] <= load_data;
      end
   end

   spmv_resp_fifo #(
      .entry_t (resp_entry_t),
      .QDEPTH  (QDEPTH)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (s1_val_q),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_entry),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_spmv_line_server.sv
module tb_spmv_line_server;
   import dcp_spmv_pkg::*;

   localparam int DEPTH  = 256;
   localparam int LINE_W = 512;
   localparam int QDEPTH = 4;
   localparam int EW     = TRANSID_W + 1 + LINE_W;

   // ---------------- clock / reset / signals ----------------
   logic                 clk = 1'b0;
   logic                 rst, flush;
   logic [PADDR_W-1:0]   base_addr;
   logic                 load_val;
   logic [7:0]           load_idx;
   logic [LINE_W-1:0]    load_data;
   logic                 mem_req_val, mem_req_rdy;
   logic [TRANSID_W-1:0] mem_req_transid;
   logic [PADDR_W-1:0]   mem_req_addr;
   logic                 mem_resp_val, mem_resp_rdy;
   logic [TRANSID_W-1:0] mem_resp_transid;
   logic [LINE_W-1:0]    mem_resp_data;
   logic                 mem_resp_err;
   logic [EW-1:0]        resp_bus;

   always #5 clk = ~clk;

   spmv_line_server #(.DEPTH(DEPTH), .LINE_W(LINE_W), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .base_addr(base_addr),
      .load_val(load_val), .load_idx(load_idx), .load_data(load_data),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
      .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
      .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
      .mem_resp_transid(mem_resp_transid), .mem_resp_data(mem_resp_data),
      .mem_resp_err(mem_resp_err)
   );

   assign resp_bus = {mem_resp_transid, mem_resp_err, mem_resp_data};

   // ---------------- scoreboard / reference model ----------------
   int                   checks = 0;
   int                   errors = 0;
   logic [LINE_W-1:0]    mm [DEPTH];
   logic [EW-1:0]        exp_q[$];
   logic                 pend_v = 1'b0;
   int                   pend_idx;
   logic                 pend_err;
   logic [TRANSID_W-1:0] pend_tid;
   int                   n_seen;
   logic [LINE_W-1:0]    a5_line, new_line;

   task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W/32; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   // Window decode straight from the address arithmetic.
   function automatic void decode(input logic [PADDR_W-1:0] addr, input logic [PADDR_W-1:0] base,
                                  output int idx, output logic err);
      longint a, b, off;
      a = longint'(addr) & ~longint'(63);
      b = longint'(base) & ~longint'(63);
      idx = 0;
      err = 1'b0;
      if (a < b) err = 1'b1;
      else begin
         off = (a - b) / 64;
         if (off >= DEPTH) err = 1'b1;
         else idx = int'(off);
      end
   endfunction

   // One clock cycle: check outputs against the model, then advance the model
   // through the coming edge. Inputs are set by the caller at posedge+1.
   task automatic do_cycle();
      logic exp_rdy, acc, err;
      int   idx;
      #1;
      exp_rdy = !rst && !flush && !load_val && ((exp_q.size() + int'(pend_v)) < QDEPTH);
      chk("req_rdy", EW'(mem_req_rdy), EW'(exp_rdy));
      chk("resp_val", EW'(mem_resp_val), EW'(!rst && exp_q.size() != 0));
      if (rst) chk("rst_resp_zero", resp_bus, '0);
      if (!rst && exp_q.size() != 0) begin
         chk("resp_head", resp_bus, exp_q[0]);
         if (mem_resp_rdy) void'(exp_q.pop_front());
      end
      acc = exp_rdy && mem_req_val;
      decode(mem_req_addr, base_addr, idx, err);
      if (rst) begin
         exp_q.delete();
         pend_v = 1'b0;
      end else begin
         if (load_val) mm[load_idx] = load_data;
         if (flush) begin
            exp_q.delete();
            pend_v = 1'b0;
         end else begin
            // The line is read the cycle after acceptance, seeing that cycle's load.
            if (pend_v) exp_q.push_back({pend_tid, pend_err, pend_err ? {LINE_W{1'b0}} : mm[pend_idx]});
            pend_v   = acc;
            pend_idx = idx;
            pend_err = err;
            pend_tid = mem_req_transid;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic req(input logic [PADDR_W-1:0] a, input logic [TRANSID_W-1:0] t);
      mem_req_val     = 1'b1;
      mem_req_addr    = a;
      mem_req_transid = t;
   endtask

   task automatic idle();
      mem_req_val = 1'b0;
      load_val    = 1'b0;
      flush       = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      rst = 1'b1; flush = 1'b0; base_addr = 40'h1000;
      load_val = 1'b0; load_idx = '0; load_data = '0;
      mem_req_val = 1'b0; mem_req_transid = '0; mem_req_addr = '0; mem_resp_rdy = 1'b0;
      a5_line = {64{8'hA5}};

      // reset state
      repeat (2) do_cycle();
      rst = 1'b0;

      // fill every line so all in-window reads have defined data
      for (int i = 0; i < DEPTH; i++) begin
         load_val  = 1'b1;
         load_idx  = 8'(i);
         load_data = (i == 3) ? a5_line : rand_line();
         do_cycle();
      end
      load_val = 1'b0;

      // basic read: 0x10C4 -> line 3, two cycles to head
      mem_resp_rdy = 1'b1;
      req(40'h10C4, 6'd7);
      do_cycle();
      idle();
      do_cycle();
      #1;
      chk("basic_val", EW'(mem_resp_val), EW'(1));
      chk("basic_resp", resp_bus, {6'd7, 1'b0, a5_line});
      do_cycle();

      // backpressure: 6 back-to-back requests, only QDEPTH accepted
      mem_resp_rdy = 1'b0;
      n_seen = 0;
      for (int i = 0; i < 6; i++) begin
         req(40'h1000 + 40'((10 + i) * 64), 6'(i + 1));
         #1;
         if (mem_req_rdy) n_seen++;
         do_cycle();
      end
      idle();
      chk("bp_accepted", EW'(n_seen), EW'(4));
      do_cycle();
      mem_resp_rdy = 1'b1;
      repeat (4) do_cycle();
      #1;
      chk("bp_rdy_back", EW'(mem_req_rdy), EW'(1));

      // out of window: below base and one line past the end
      req(40'h0FC0, 6'd20);
      do_cycle();
      req(40'h1000 + 40'(256 * 64), 6'd21);
      do_cycle();
      idle();
      #1;
      chk("oow_low", resp_bus, {6'd20, 1'b1, {LINE_W{1'b0}}});
      do_cycle();
      #1;
      chk("oow_high", resp_bus, {6'd21, 1'b1, {LINE_W{1'b0}}});
      do_cycle();

      // load priority: same-cycle load blocks the request
      new_line = rand_line();
      req(40'h1000 + 40'(5 * 64), 6'd30);
      load_val = 1'b1; load_idx = 8'd5; load_data = new_line;
      #1;
      chk("ldpri_rdy", EW'(mem_req_rdy), EW'(0));
      do_cycle();
      load_val = 1'b0;
      do_cycle();
      idle();
      do_cycle();
      #1;
      chk("ldpri_resp", resp_bus, {6'd30, 1'b0, new_line});
      do_cycle();

      // load in the cycle after acceptance is seen by the response
      new_line = rand_line();
      req(40'h1000 + 40'(6 * 64) + 40'h11, 6'd31);
      do_cycle();
      idle();
      load_val = 1'b1; load_idx = 8'd6; load_data = new_line;
      do_cycle();
      load_val = 1'b0;
      #1;
      chk("late_load_resp", resp_bus, {6'd31, 1'b0, new_line});
      do_cycle();

      // flush with 3 outstanding
      mem_resp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req(40'h1000 + 40'((20 + i) * 64), 6'(40 + i));
         do_cycle();
      end
      idle();
      flush = 1'b1;
      do_cycle();
      flush = 1'b0;
      #1;
      chk("flush_val", EW'(mem_resp_val), EW'(0));
      chk("flush_rdy", EW'(mem_req_rdy), EW'(1));
      repeat (2) do_cycle();
      mem_resp_rdy = 1'b1;
      req(40'h1000 + 40'(9 * 64), 6'd43);
      do_cycle();
      idle();
      do_cycle();
      #1;
      chk("flush_after", resp_bus, {6'd43, 1'b0, mm[9]});
      do_cycle();

      // reset with 2 entries queued
      mem_resp_rdy = 1'b0;
      req(40'h1000 + 40'(3 * 64), 6'd50);
      do_cycle();
      req(40'h1000 + 40'(7 * 64), 6'd51);
      do_cycle();
      idle();
      do_cycle();
      rst = 1'b1;
      do_cycle();
      rst = 1'b0;
      #1;
      chk("rst_mid_val", EW'(mem_resp_val), EW'(0));
      repeat (2) do_cycle();
      mem_resp_rdy = 1'b1;
      req(40'h1000 + 40'(3 * 64), 6'd52);
      do_cycle();
      idle();
      do_cycle();
      #1;
      chk("rst_line_kept", resp_bus, {6'd52, 1'b0, a5_line});
      do_cycle();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         int r;
         base_addr       = 40'h1000 + 40'($urandom_range(0, 63));
         mem_req_val     = ($urandom_range(0, 3) != 0);
         mem_req_transid = 6'($urandom());
         r = $urandom_range(0, 9);
         if (r == 0)
            mem_req_addr = 40'h1000 - 40'($urandom_range(1, 4) * 64) + 40'($urandom_range(0, 63));
         else if (r == 1)
            mem_req_addr = 40'h1000 + 40'(($urandom_range(256, 259)) * 64) + 40'($urandom_range(0, 63));
         else
            mem_req_addr = 40'h1000 + 40'($urandom_range(0, 255) * 64) + 40'($urandom_range(0, 63));
         mem_resp_rdy = ($urandom_range(0, 3) != 0);
         load_val     = ($urandom_range(0, 9) == 0);
         load_idx     = 8'($urandom_range(0, 255));
         load_data    = rand_line();
         flush        = ($urandom_range(0, 49) == 0);
         do_cycle();
      end

      // drain
      idle();
      base_addr    = 40'h1000;
      mem_resp_rdy = 1'b1;
      repeat (10) do_cycle();
      #1;
      chk("drain_val", EW'(mem_resp_val), EW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
